// File: rtl/m4_pkg.sv
// m4_pkg: shared state encoding, mode constants and default frame geometry for m4_capture
package m4_pkg;
  typedef enum logic [1:0] {CLEAR, WAIT_VS, CAPTURE} state_t;
  localparam logic M64 = 1'b0;
  localparam logic M80 = 1'b1;
  localparam int FB_W_DEF = 800;
  localparam int FB_H_DEF = 240;
  localparam int ADDR_W_DEF = 18;
endpackage

// File: rtl/m4_sync_edge.sv
// m4_sync_edge: multi-flop synchroniser with single-cycle rise/fall pulses
module m4_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic dotclk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] s;
  logic p;
  always_ff @(posedge dotclk)
    if (reset) begin
      s <= '0;
      p <= 1'b0;
    end else begin
      s <= {s[SYNC_STAGES-2:0], d};
      p <= s[SYNC_STAGES-1];
    end
  assign q = s[SYNC_STAGES-1];
  assign rise = q & ~p;
  assign fall = ~q & p;
endmodule

// File: rtl/m4_capture.sv
// m4_capture: samples TRS-80 Model 4 video on the dot clock and writes pixels into the frame RAM
module m4_capture
  import m4_pkg::*;
#(
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W = 10,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_VALID = 320,
  parameter int MODE_THRESH = 720,
  parameter int MODE_CONFIRM = 2,
  parameter int X_OFF64 = 16,
  parameter int Y_OFF64 = 0,
  parameter int X_OFF80 = -71,
  parameter int Y_OFF80 = 8
) (
  input  logic              dotclk,
  input  logic              reset,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              video,
  output logic [ADDR_W-1:0] waddr,
  output logic              wdata,
  output logic              wren,
  output logic              mode80,
  output logic              clearing,
  output logic [CNT_W-1:0]  line_len,
  output logic              heartbeat
);
  localparam int AW2 = ADDR_W + 2;
  localparam int AGW = $clog2(MODE_CONFIRM + 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_W * FB_H - 1);
  localparam logic [ADDR_W-1:0] W_A = ADDR_W'(FB_W);
  localparam logic signed [AW2-1:0] W_S = AW2'(FB_W);
  localparam logic signed [AW2-1:0] H_S = AW2'(FB_H);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_VALID);
  localparam logic [CNT_W-1:0] THR = CNT_W'(MODE_THRESH);
  localparam logic [AGW-1:0] CONF = AGW'(MODE_CONFIRM);
  state_t state;
  logic [ADDR_W-1:0] clr_cnt, pix_addr;
  logic [CNT_W-1:0] x, y, fmax;
  logic [AGW-1:0] agree, agree_nx;
  logic [20:0] hb;
  logic signed [AW2-1:0] row, col;
  logic in_fb, cand;
  logic hs_q, hs_rise, hs_fall, vs_q, vs_rise, vs_fall, vd_q, vd_rise, vd_fall;
  logic unused_edges;
  m4_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_hs (.dotclk(dotclk), .reset(reset), .d(hsync), .q(hs_q), .rise(hs_rise), .fall(hs_fall));
  m4_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_vs (.dotclk(dotclk), .reset(reset), .d(vsync), .q(vs_q), .rise(vs_rise), .fall(vs_fall));
  m4_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_vd (.dotclk(dotclk), .reset(reset), .d(video), .q(vd_q), .rise(vd_rise), .fall(vd_fall));
  assign unused_edges = ^{hs_q, hs_rise, vd_rise, vd_fall};
  always_comb begin
    row = $signed(AW2'(y)) - (mode80 ? AW2'(Y_OFF80) : AW2'(Y_OFF64));
    col = $signed(AW2'(x)) + (mode80 ? AW2'(X_OFF80) : AW2'(X_OFF64));
    in_fb = !row[AW2-1] && row < H_S && !col[AW2-1] && col < W_S;
    pix_addr = row[ADDR_W-1:0] * W_A + col[ADDR_W-1:0];
    cand = fmax > THR ? M80 : M64;
    agree_nx = agree + 1'b1;
  end
  always_ff @(posedge dotclk)
    if (reset) begin
      state <= CLEAR;
      clr_cnt <= '0;
      x <= '0;
      y <= '0;
      fmax <= '0;
      agree <= '0;
      waddr <= '0;
      wdata <= 1'b0;
      wren <= 1'b0;
      mode80 <= M64;
      clearing <= 1'b1;
      line_len <= '0;
    end else begin
      clearing <= state == CLEAR;
      case (state)
        CLEAR: begin
          wren <= 1'b1;
          wdata <= 1'b0;
          waddr <= clr_cnt;
          clr_cnt <= clr_cnt == LAST ? '0 : clr_cnt + 1'b1;
          if (clr_cnt == LAST) state <= WAIT_VS;
        end
        WAIT_VS: begin
          wren <= 1'b0;
          if (vs_rise) begin
            x <= '0;
            y <= '0;
            fmax <= '0;
            state <= CAPTURE;
          end
        end
        default: begin
          if (!vs_q) begin
            x <= '0;
            y <= '0;
            wren <= 1'b0;
            if (vs_fall) begin
              line_len <= fmax;
              fmax <= '0;
              if (fmax > MIN_V) begin
                if (cand != mode80) begin
                  if (agree_nx == CONF) begin
                    mode80 <= cand;
                    agree <= '0;
                    clr_cnt <= '0;
                    state <= CLEAR;
                  end else agree <= agree_nx;
                end else agree <= '0;
              end
            end
          end else if (hs_fall) begin
            fmax <= x > fmax ? x : fmax;
            x <= '0;
            y <= &y ? y : y + 1'b1;
            wren <= 1'b0;
          end else begin
            wren <= in_fb;
            wdata <= vd_q;
            waddr <= pix_addr;
            x <= &x ? x : x + 1'b1;
          end
        end
      endcase
    end
  always_ff @(posedge dotclk)
    if (reset) hb <= '0;
    else hb <= hb + 1'b1;
  assign heartbeat = hb[20];
endmodule

// File: tb/tb_m4_capture.sv
// tb_m4_capture: directed self-checking bench for m4_capture on a reduced-height frame buffer
module tb_m4_capture;
  localparam int FB_W = 800;
  localparam int FB_H = 4;
  localparam int ADDR_W = 18;
  localparam int DEPTH = FB_W * FB_H;
  logic dotclk = 1'b0;
  logic reset = 1'b1;
  logic hsync = 1'b1;
  logic vsync = 1'b1;
  logic video = 1'b0;
  logic [ADDR_W-1:0] waddr;
  logic wdata, wren, mode80, clearing, heartbeat;
  logic [9:0] line_len;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int ones = 0;
  int one_addr = -1;
  int clr_seen = 0;
  int clr_bad = 0;
  m4_capture #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W)) dut (
    .dotclk(dotclk), .reset(reset), .hsync(hsync), .vsync(vsync), .video(video),
    .waddr(waddr), .wdata(wdata), .wren(wren), .mode80(mode80), .clearing(clearing),
    .line_len(line_len), .heartbeat(heartbeat)
  );
  always #5 dotclk = ~dotclk;
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge dotclk);
    #1;
    if (!reset) begin
      if (clearing) begin
        if (wren && !wdata && waddr == ADDR_W'(clr_seen)) clr_seen++;
        else clr_bad++;
      end else if (wren) begin
        wr_cnt++;
        if (wdata) begin
          ones++;
          one_addr = int'(waddr);
        end
      end
    end
  endtask
  task automatic dot(input logic h, input logic v, input logic d);
    hsync = h;
    vsync = v;
    video = d;
    step();
  endtask
  task automatic blank();
    repeat (8) dot(1'b1, 1'b0, 1'b0);
  endtask
  task automatic frame(input int len, input int lines, input int px0, input int py0, input int px1, input int py1);
    blank();
    wr_cnt = 0;
    ones = 0;
    one_addr = -1;
    clr_seen = 0;
    clr_bad = 0;
    for (int yy = 0; yy < lines; yy++) begin
      for (int j = 0; j < len; j++)
        dot(1'b1, 1'b1, (j == px0 && yy == py0) || (j == px1 && yy == py1));
      dot(1'b0, 1'b1, 1'b0);
    end
  endtask
  task automatic run_clear(input string tag);
    int n;
    n = 0;
    while (clearing && n < 20000) begin
      step();
      n++;
    end
    chk({tag, "_timeout"}, int'(n < 20000), 1);
    chk({tag, "_writes"}, clr_seen, DEPTH);
    chk({tag, "_bad"}, clr_bad, 0);
    chk({tag, "_idle_wren"}, int'(wren), 0);
  endtask
  initial begin
    int n;
    step();
    step();
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_wdata", int'(wdata), 0);
    chk("rst_wren", int'(wren), 0);
    chk("rst_mode80", int'(mode80), 0);
    chk("rst_clearing", int'(clearing), 1);
    chk("rst_line_len", int'(line_len), 0);
    chk("rst_heartbeat", int'(heartbeat), 0);
    clr_seen = 0;
    clr_bad = 0;
    reset = 1'b0;
    step();
    chk("clr_first_addr", int'(waddr), 0);
    chk("clr_first_wren", int'(wren), 1);
    run_clear("clr0");
    chk("clr0_clearing_low", int'(clearing), 0);
    frame(640, 4, 5, 3, -1, -1);
    blank();
    chk("m64_ones", ones, 1);
    chk("m64_addr", one_addr, 2421);
    chk("m64_writes", wr_cnt, 2559);
    chk("m64_line_len", int'(line_len), 640);
    chk("m64_mode", int'(mode80), 0);
    frame(800, 2, -1, -1, -1, -1);
    blank();
    chk("sw1_mode_held", int'(mode80), 0);
    chk("sw1_line_len", int'(line_len), 800);
    chk("sw1_no_clear", int'(clearing), 0);
    frame(800, 2, -1, -1, -1, -1);
    blank();
    chk("sw2_mode80", int'(mode80), 1);
    run_clear("clr80");
    frame(800, 11, 100, 10, -1, -1);
    blank();
    chk("m80_ones", ones, 1);
    chk("m80_addr", one_addr, 1629);
    chk("m80_writes", wr_cnt, 2187);
    chk("m80_line_len", int'(line_len), 800);
    frame(800, 11, 5, 4, 50, 10);
    blank();
    chk("oob_ones", ones, 0);
    chk("oob_writes", wr_cnt, 2187);
    chk("oob_line_len", int'(line_len), 800);
    frame(640, 2, -1, -1, -1, -1);
    blank();
    chk("back1_mode_held", int'(mode80), 1);
    chk("back1_line_len", int'(line_len), 640);
    frame(200, 3, -1, -1, -1, -1);
    blank();
    chk("short_mode", int'(mode80), 1);
    chk("short_line_len", int'(line_len), 200);
    chk("short_no_clear", int'(clearing), 0);
    frame(640, 2, -1, -1, -1, -1);
    blank();
    chk("back2_mode64", int'(mode80), 0);
    n = 0;
    while (clr_seen < 1000 && n < 5000) begin
      step();
      n++;
    end
    chk("partial_clear", clr_seen, 1000);
    chk("partial_bad", clr_bad, 0);
    reset = 1'b1;
    step();
    chk("mid_rst_clearing", int'(clearing), 1);
    chk("mid_rst_wren", int'(wren), 0);
    clr_seen = 0;
    clr_bad = 0;
    reset = 1'b0;
    step();
    chk("mid_rst_first_addr", int'(waddr), 0);
    run_clear("clr_rst");
    frame(400, 2, -1, -1, -1, -1);
    for (int j = 0; j < 500; j++) dot(1'b1, 1'b1, 1'b0);
    dot(1'b0, 1'b0, 1'b0);
    blank();
    chk("collide_line_len", int'(line_len), 400);
    chk("collide_mode", int'(mode80), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
